// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register with a valid/ready load port and a
// clock-enable bit strobe; back-to-back words are sent with no idle gap.
//
// state | meaning
// IDLE  | no word in flight, load_ready high, sout/sout_valid low
// SHIFT | word in flight, sout carries the current bit
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_sout;
    logic             r_sout_valid;
    logic             r_done;
    logic             w_last;
    logic             w_load;
    logic             w_sout_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sout       <= w_sout_nxt;
            r_sout_valid <= (w_state_nxt == SHIFT);
            r_done       <= w_last;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;

        w_last     = (r_state == SHIFT) && shift_en && (r_cnt == LAST);
        load_ready = (r_state == IDLE) || w_last;
        w_load     = load_valid && load_ready;

        if (w_load) begin
            w_state_nxt = SHIFT;
            w_shreg_nxt = load_data;
            w_cnt_nxt   = '0;
        end else if ((r_state == SHIFT) && shift_en) begin
            if (w_last) begin
                w_state_nxt = IDLE;
                w_shreg_nxt = '0;
                w_cnt_nxt   = '0;
            end else begin
                w_shreg_nxt = LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);
                w_cnt_nxt   = r_cnt + CW'(1);
            end
        end

        // sout is registered, so it is fed from the bit that will be current next cycle
        w_sout_nxt = (w_state_nxt == SHIFT) &&
                     (LSB_FIRST ? w_shreg_nxt[0] : w_shreg_nxt[WIDTH-1]);
    end

    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign busy       = (r_state == SHIFT);
    assign done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus;
// a queue scoreboard checks every cycle, a vector table checks whole words.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       shift_en = 1'b0;

    logic rdy_m, sout_m, sval_m, busy_m, done_m;
    logic rdy_l, sout_l, sval_l, busy_l, done_l;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_m), .shift_en(shift_en), .sout(sout_m),
        .sout_valid(sval_m), .busy(busy_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_l), .shift_en(shift_en), .sout(sout_l),
        .sout_valid(sval_l), .busy(busy_l), .done(done_l)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: one entry per bit still to be sent, in send order for each instance.
    typedef struct packed {
        logic bm;
        logic bl;
    } sb_t;
    sb_t         q[$];
    logic        m_done = 1'b0;
    logic [15:0] cap_m = '0;
    logic [15:0] cap_l = '0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_done = 1'b0;
        end else begin
            automatic logic exp_busy = (q.size() != 0);
            automatic logic consume  = exp_busy && shift_en;
            automatic logic last     = consume && (q.size() == 1);
            automatic logic m_ready  = !exp_busy || last;
            chk("sout_msb",  sout_m, exp_busy ? q[0].bm : 1'b0);
            chk("sout_lsb",  sout_l, exp_busy ? q[0].bl : 1'b0);
            chk("valid_msb", sval_m, exp_busy);
            chk("valid_lsb", sval_l, exp_busy);
            chk("busy_msb",  busy_m, exp_busy);
            chk("busy_lsb",  busy_l, exp_busy);
            chk("done_msb",  done_m, m_done);
            chk("done_lsb",  done_l, m_done);
            chk("ready_msb", rdy_m,  m_ready);
            chk("ready_lsb", rdy_l,  m_ready);
            if (done_m) n_done++;
            if (consume) begin
                cap_m = {cap_m[14:0], sout_m};
                cap_l = {cap_l[14:0], sout_l};
                void'(q.pop_front());
            end
            m_done = last;
            if (load_valid && m_ready) begin
                for (int k = 0; k < 8; k++) q.push_back({load_data[7-k], load_data[k]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input logic [7:0] data, input int period);
        automatic bit got = 1'b0;
        load_valid = 1'b1;
        load_data  = data;
        shift_en   = 1'b0;
        tick();
        load_valid = 1'b0;
        load_data  = 8'($urandom);
        for (int c = 0; c < 200 && !got; c++) begin
            shift_en = ((c % period) == (period - 1));
            tick();
            if (done_m) got = 1'b1;
        end
        shift_en = 1'b0;
        if (!got) chk("word_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        int         period;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;
    vec_t tbl[5];

    initial begin
        automatic int nd0;
        tbl[0] = '{8'hA5, 1, 8'hA5, 8'hA5};
        tbl[1] = '{8'h01, 1, 8'h01, 8'h80};
        tbl[2] = '{8'hC3, 3, 8'hC3, 8'hC3};
        tbl[3] = '{8'h80, 2, 8'h80, 8'h01};
        tbl[4] = '{8'h3A, 1, 8'h3A, 8'h5C};

        #1 rst = 1'b1;
        #3;
        chk("rst_sout",  {sout_m, sout_l}, 2'b00);
        chk("rst_valid", {sval_m, sval_l}, 2'b00);
        chk("rst_busy",  {busy_m, busy_l}, 2'b00);
        chk("rst_done",  {done_m, done_l}, 2'b00);
        chk("rst_ready", {rdy_m, rdy_l},   2'b11);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            nd0 = n_done;
            run_word(tbl[i].data, tbl[i].period);
            tick();
            chk($sformatf("vec%0d_msb", i), cap_m[7:0], tbl[i].exp_m);
            chk($sformatf("vec%0d_lsb", i), cap_l[7:0], tbl[i].exp_l);
            chk($sformatf("vec%0d_done_count", i), n_done - nd0, 1);
        end

        // back-to-back words with no gap
        nd0 = n_done;
        load_valid = 1'b1;
        load_data  = 8'hF0;
        shift_en   = 1'b1;
        tick();
        load_data = 8'h0F;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("b2b_ready_c%0d", k), rdy_m, (k == 7));
        end
        tick();
        load_valid = 1'b0;
        chk("b2b_done_first", done_m, 1'b1);
        for (int c = 0; c < 40 && (n_done - nd0) < 2; c++) tick();
        shift_en = 1'b0;
        tick();
        chk("b2b_stream_msb", cap_m, 16'hF00F);
        chk("b2b_stream_lsb", cap_l, 16'h0FF0);
        chk("b2b_done_count", n_done - nd0, 2);

        // reset in the middle of a word
        nd0 = n_done;
        load_valid = 1'b1;
        load_data  = 8'hFF;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        chk("midrst_sout",  {sout_m, sout_l}, 2'b00);
        chk("midrst_valid", {sval_m, sval_l}, 2'b00);
        chk("midrst_busy",  {busy_m, busy_l}, 2'b00);
        tick();
        rst = 1'b0;
        shift_en = 1'b0;
        tick();
        chk("midrst_no_done", n_done - nd0, 0);
        run_word(8'h80, 1);
        tick();
        chk("postrst_msb", cap_m[7:0], 8'h80);
        chk("postrst_lsb", cap_l[7:0], 8'h01);
        chk("postrst_done_count", n_done - nd0, 1);

        // load_valid held while busy with changing data: only the final-bit value is taken
        nd0 = n_done;
        load_valid = 1'b1;
        load_data  = 8'h3C;
        shift_en   = 1'b1;
        tick();
        for (int k = 1; k <= 7; k++) begin
            load_data = 8'($urandom);
            tick();
            chk($sformatf("hold_ready_c%0d", k), rdy_m, (k == 7));
        end
        load_data = 8'h96;
        tick();
        load_valid = 1'b0;
        load_data  = 8'($urandom);
        for (int c = 0; c < 40 && (n_done - nd0) < 2; c++) tick();
        shift_en = 1'b0;
        tick();
        chk("hold_stream_msb", cap_m, 16'h3C96);
        chk("hold_stream_lsb", cap_l, 16'h3C69);
        chk("hold_done_count", n_done - nd0, 2);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out shift register. It is the transmit end of the serial shift-register link: it loads a parallel word and drives it one bit at a time onto a serial line.
- That line feeds downstream serial-in shift registers, for example a SISO chain or a SIPO receiver.
- The word is accepted through a valid/ready handshake. Bit rate is paced by a clock-enable strobe.
- Back-to-back words are supported with no idle gap.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- LSB_FIRST, 0, bit order: 0 sends the MSB first, 1 sends the LSB first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  upstream presents a word on load_data.
- load_data  input  WIDTH  parallel word to send.
- load_ready  output  1  block can accept a word this cycle (combinational).
- shift_en  input  1  bit-rate strobe; advances the serial output by one bit.
- sout  output  1  serial data out (registered).
- sout_valid  output  1  sout carries a valid bit (registered).
- busy  output  1  a word is in flight (state == SHIFT).
- done  output  1  one-cycle pulse after the final bit of a word is consumed.

Behaviour:
Reset:
- rst forces state = IDLE, shift register = 0, bit counter = 0, sout = 0, sout_valid = 0, done = 0.
- Reset applied mid-word aborts the word immediately. The word is discarded and no done pulse is issued.

State machine, two states: IDLE and SHIFT.
- IDLE:
  - load_ready = 1.
  - A load occurs when load_valid = 1 and load_ready = 1. On that edge, load_data is captured, the counter is cleared and the state becomes SHIFT.
  - sout shows the first bit from the following cycle: load_data[WIDTH-1] if LSB_FIRST = 0, else load_data[0].
- SHIFT:
  - sout_valid = 1 and sout holds the current bit.
  - Each edge with shift_en = 1 moves to the next bit and increments the counter. The shift register shifts left (MSB-first) or right (LSB-first) and zero-fills.
  - shift_en = 0 holds sout, the counter and the state unchanged.
- Final bit: the counter equals WIDTH-1 and shift_en = 1. On that edge:
  - done is set to 1 for exactly one cycle.
  - If load_valid = 1, the new word is loaded, the state stays SHIFT, and the new word's first bit appears the next cycle with no gap.
  - Otherwise the state becomes IDLE, sout_valid = 0 and sout = 0.
- load_ready in SHIFT is 1 only during the final-bit cycle with shift_en = 1; it is 0 otherwise. load_valid in SHIFT outside that cycle is ignored. Upstream must hold the word.
- In IDLE, shift_en has no effect.

Latency and timing:
- A word occupies exactly WIDTH shift_en strobes.
- With shift_en tied to 1: load edge E0, bit k visible during cycle E(k)..E(k+1), done high during E(WIDTH)..E(WIDTH+1).
- load_data is sampled only on the accepting edge. Later changes have no effect on the word in flight.

Test Plan:
1. WIDTH=8, LSB_FIRST=0, shift_en=1, load 8'hA5 -> sout = 1,0,1,0,0,1,0,1 on cycles 1..8. sout_valid high for those 8 cycles. done high on cycle 9 only. busy low from cycle 9.
2. LSB_FIRST=1, load 8'hA5, shift_en=1 -> sout = 1,0,1,0,0,1,0,1 (LSB first). Also load 8'h01 -> sout = 1,0,0,0,0,0,0,0.
3. shift_en asserted every 3rd cycle, load 8'hC3 -> each bit held for 3 cycles. Sequence 1,1,0,0,0,0,1,1. done exactly one cycle after the 8th strobe.
4. Back-to-back: load 8'hF0, keep load_valid=1 with load_data=8'h0F, shift_en=1 -> load_ready high only on cycle 8. 16 contiguous valid bits 1111000000001111 with no gap. done pulses on cycles 9 and 17.
5. Reset mid-word: load 8'hFF, assert rst asynchronously between edges after the 3rd bit -> sout, sout_valid and busy go to 0 immediately. No done pulse. The next load of 8'h80 sends 1,0,0,0,0,0,0,0 from bit 0.
6. load_valid held high while busy (not the final bit), with load_data changing -> load_ready = 0, the in-flight word is unaffected, and only the value present at the final-bit edge is accepted.
